// File: rtl/systolic_n_body_pkg.sv
// systolic_n_body_pkg: shared fixed-point types, default widths and collector states
package systolic_n_body_pkg;
  localparam int FIXED_W = 32;
  localparam int FIXED_FRAC = 16;
  typedef logic signed [FIXED_W-1:0] fixed_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} collector_state_t;
  localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_W-1){1'b0}}};
endpackage

// File: rtl/systolic_n_body_sat_add.sv
// systolic_n_body_sat_add: saturating signed sum of one accumulator and ROWS terms
// acc: current value; terms: ROWS packed W-bit addends (zero when absent)
// sum: clamped W-bit result; sat: result was clamped
module systolic_n_body_sat_add #(
  parameter int W = 32,
  parameter int ROWS = 2
) (
  input  logic [W-1:0]      acc,
  input  logic [ROWS*W-1:0] terms,
  output logic [W-1:0]      sum,
  output logic              sat
);
  logic signed [W+1:0] s;
  always_comb begin
    s = (W+2)'($signed(acc));
    for (int r = 0; r < ROWS; r++) s = s + (W+2)'($signed(terms[r*W +: W]));
  end
  // the W-bit result fits only if the three top bits agree
  assign sat = !(&s[W+1:W-1] || !(|s[W+1:W-1]));
  assign sum = sat ? {s[W+1], {(W-1){!s[W+1]}}} : s[W-1:0];
endmodule

// File: rtl/systolic_n_body_2x2_force_collector.sv
// systolic_n_body_2x2_force_collector: per-body accumulation of row-edge forces, drained in body order
// clk/reset: clock, async active-low reset
// in_start/in_valid/in_idx/in_p/in_last: sweep control and per-row contributions
// out_valid/out_ready/out_idx/out_a: acceleration stream to the integrator
// busy/done/overflow/idx_err: status
module systolic_n_body_2x2_force_collector
  import systolic_n_body_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int NBODY = 4,
  parameter int W     = FIXED_W,
  parameter int FRAC  = FIXED_FRAC,
  parameter int IDXW  = $clog2(NBODY)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_start,
  input  logic [ROWS-1:0]      in_valid,
  input  logic [ROWS*IDXW-1:0] in_idx,
  input  logic [ROWS*W-1:0]    in_p,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_idx,
  output logic [W-1:0]         out_a,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 idx_err
);
  if (FRAC < 0 || FRAC >= W) begin : g_frac_chk
    $error("FRAC must lie in [0, W)");
  end
  collector_state_t state, state_nx;
  logic [NBODY-1:0][W-1:0] acc, acc_nx;
  logic [NBODY-1:0]        sat;
  logic [IDXW-1:0]         ptr;
  logic                    bad_idx, fire, last_beat, clr, add;
  for (genvar j = 0; j < NBODY; j++) begin : g_ent
    logic [ROWS*W-1:0] terms;
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign terms[r*W +: W] = (in_valid[r] && in_idx[r*IDXW +: IDXW] == IDXW'(j)) ? in_p[r*W +: W] : '0;
    end
    systolic_n_body_sat_add #(.W(W), .ROWS(ROWS)) u_add (
      .acc  (acc[j]),
      .terms(terms),
      .sum  (acc_nx[j]),
      .sat  (sat[j])
    );
  end
  always_comb begin
    bad_idx = 1'b0;
    for (int r = 0; r < ROWS; r++)
      bad_idx = bad_idx | (in_valid[r] && 32'(in_idx[r*IDXW +: IDXW]) >= NBODY);
  end
  assign fire      = state == DRAIN && out_ready;
  assign last_beat = ptr == IDXW'(NBODY-1);
  assign clr       = in_start && state != DRAIN;
  // a restart cycle discards its own contributions
  assign add       = state == ACCUM && !in_start;
  assign out_valid = state == DRAIN;
  assign busy      = state != IDLE;
  assign out_idx   = ptr;
  always_comb begin
    out_a = '0;
    for (int j = 0; j < NBODY; j++) if (out_valid && ptr == IDXW'(j)) out_a = acc[j];
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_start) state_nx = ACCUM;
    if (state == ACCUM && !in_start && in_last) state_nx = DRAIN;
    if (fire && last_beat) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      ptr      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      idx_err  <= 1'b0;
    end else begin
      done <= fire && last_beat;
      if (clr) begin
        acc      <= '0;
        overflow <= 1'b0;
        idx_err  <= 1'b0;
      end else if (add) begin
        acc      <= acc_nx;
        overflow <= overflow | (|sat);
        idx_err  <= idx_err | bad_idx;
      end
      if (fire) ptr <= last_beat ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: doc/systolic_n_body_2x2_force_collector.md
Name: systolic_n_body_2x2_force_collector

Overview:
- Receiving end of the 2x2 systolic array's force outputs.
- Takes the partial-force contributions leaving the array's row edges (the out_p_right stream of each row) and accumulates them per body over one force sweep.
- Once the sweep ends, streams the per-body accelerations in body order, over a valid/ready handshake, to the Verlet integration stage (its in_a_t input).
- Fixed-point, synthesizable.

Parameters:
- ROWS, 2: array rows, i.e. number of parallel contribution inputs.
- NBODY, 4: bodies per sweep, i.e. accumulator entries.
- W, 32: signed fixed-point data width.
- FRAC, 16: fractional bits (Q(W-FRAC).FRAC); carried for documentation only, because the arithmetic is format-agnostic.
- IDXW, $clog2(NBODY): body index width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_start  in  1  one-cycle pulse: clear all accumulators and begin a sweep
- in_valid  in  ROWS  per-row contribution valid
- in_idx  in  ROWS*IDXW  per-row target body index
- in_p  in  ROWS*W  per-row signed partial force/acceleration
- in_last  in  1  final beat of the sweep
- out_valid  out  1  acceleration beat available
- out_ready  in  1  integrator accepts beat
- out_idx  out  IDXW  body index of current beat
- out_a  out  W  accumulated acceleration of out_idx
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final drain transfer
- overflow  out  1  sticky: any accumulation saturated
- idx_err  out  1  sticky: valid contribution with in_idx >= NBODY

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; all accumulators 0; drain pointer 0; out_valid=0, out_idx=0, out_a=0, busy=0, done=0, overflow=0, idx_err=0.
- Reset asserted mid-sweep or mid-drain aborts immediately to the reset state; no partial output follows.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - in_valid and in_last are ignored.
  - in_start -> ACCUM. The same edge zeroes all accumulators and clears overflow and idx_err.
- ACCUM:
  - Each edge, every row with in_valid=1 and a legal index adds in_p to acc[in_idx].
  - Two rows targeting the same index: both contributions are summed together with acc in one W+2-bit add, then saturated once.
  - Saturation clamps to [-2^(W-1), 2^(W-1)-1] and sets overflow.
  - A valid row with illegal index: contribution dropped, idx_err set.
  - in_last=1 -> DRAIN next cycle. Contributions presented in the in_last cycle are included.
  - in_start during ACCUM restarts the sweep: clear accumulators and flags, remain in ACCUM. Contributions in that same cycle are discarded.
  - in_start and in_last together: in_start wins.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle, which is exactly 1 cycle after the in_last cycle.
  - out_idx = drain pointer, starting at 0; out_a = acc[out_idx] (post-update value).
  - On out_valid && out_ready the pointer increments. out_idx/out_a hold stable while out_ready=0 (AXI-style: no retraction).
  - After the transfer of index NBODY-1: out_valid=0 and state=IDLE on the next edge, with done=1 for that one cycle.
  - in_start, in_valid and in_last are ignored in DRAIN.
- Throughput: one contribution per row per cycle; one output per cycle when out_ready is held high.
- Sweep latency from in_last to done = NBODY+1 cycles with out_ready=1.

Decomposition:
- Package systolic_n_body_pkg holds:
  - W and FRAC defaults
  - typedef fixed_t (logic signed [W-1:0])
  - state enum collector_state_t {IDLE, ACCUM, DRAIN}
  - constants FIXED_MAX and FIXED_MIN
- Sub-module systolic_n_body_sat_add: combinational 3-input (acc + up to ROWS terms, zero when absent) signed add at W+2 bits with clamp and sat flag. Instantiated once per accumulator entry.

Test Plan (NBODY=4, W=32, FRAC=16; values in Q16.16 hex):
- Basic sweep:
  - Stimulus: in_start; row0 idx0 +0x00010000, row1 idx1 +0x00020000; next cycle row0 idx0 -0x00008000 with in_last; out_ready=1.
  - Required: beats idx0..3 = 0x00008000, 0x00020000, 0, 0 on 4 consecutive cycles, first beat 1 cycle after in_last; done 1 cycle after the idx3 transfer.
- Collision:
  - Stimulus: both rows idx2, +0x00030000 and +0x00010000, same cycle, in_last.
  - Required: out_a for idx2 = 0x00040000.
- Saturation:
  - Stimulus: acc[1] driven to 0x7FFF0000, then +0x00020000.
  - Required: idx1 beat = 0x7FFFFFFF, overflow=1. Next in_start clears overflow.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles at idx1.
  - Required: out_idx=1 and out_a stable throughout; no beat lost or duplicated; drain completes in order.
- Illegal index / restart:
  - Stimulus: in_idx=5 with NBODY=4 (IDXW=3 variant) -> idx_err=1, all outputs 0. Then in_start mid-ACCUM.
  - Required: accumulators read 0 on the following sweep.
- Async reset mid-DRAIN:
  - Stimulus: assert reset between clock edges during idx2.
  - Required: out_valid=0 and busy=0 immediately; state IDLE after release.
